// File: rtl/space_invaders_pkg.sv
// Shared constants, laser state encoding and position payload for the space invaders blocks.
package space_invaders_pkg;

  localparam int unsigned COORD_W = 11;
  localparam int unsigned PIX_W   = 10;
  localparam int unsigned RGB_W   = 8;
  localparam int unsigned CNT_W   = 4;

  localparam logic [COORD_W-1:0] SCREEN_W = 11'd640;
  localparam logic [COORD_W-1:0] SCREEN_H = 11'd480;
  localparam logic [1:0]         MODE_PLAY = 2'd2;

  localparam logic [RGB_W-1:0]   COLOR_LASER = 8'b11111111;
  localparam logic [RGB_W-1:0]   COLOR_BLACK = 8'b00000000;
  localparam logic [COORD_W-1:0] PARK_COORD  = 11'd2047;

  localparam logic [COORD_W-1:0] SPACESHIP_Y     = 11'd440;
  localparam logic [COORD_W-1:0] LASER_HEIGHT    = 11'd10;
  localparam logic [COORD_W-1:0] LASER_HALF_W    = 11'd1;
  localparam logic [COORD_W-1:0] LASER_SPEED     = 11'd4;
  localparam logic [CNT_W-1:0]   COOLDOWN_FRAMES = 4'd8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLYING   = 2'd1,
    HIT_HOLD = 2'd2,
    COOLDOWN = 2'd3
  } laser_state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } laser_pos_t;

  // Left edge of a centred sprite, clamped at column 0.
  function automatic logic [COORD_W-1:0] clamp_left(input logic [COORD_W-1:0] centre,
                                                     input logic [COORD_W-1:0] half_w);
    return (centre < half_w) ? '0 : COORD_W'(centre - half_w);
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// One-cycle frame strobe on the rising edge of the raster reaching pixel (0,0).
module frame_tick_gen
  import space_invaders_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] xCoord,
  input  logic [PIX_W-1:0] yCoord,
  output logic             frame_tick
);

  logic at_origin;
  logic at_origin_q;

  assign at_origin  = (xCoord == '0) && (yCoord == '0);
  assign frame_tick = at_origin && !at_origin_q;

  always_ff @(posedge clk) begin
    if (!rst) at_origin_q <= 1'b0;
    else      at_origin_q <= at_origin;
  end

endmodule

// File: rtl/spaceship_laser.sv
// Player laser: launches on a fire press, climbs once per frame, reports one score pulse per hit.
module spaceship_laser
  import space_invaders_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               restart,
  input  logic [1:0]         mode,
  input  logic               fire,
  input  logic [COORD_W-1:0] spaceship_xCoord,
  input  logic [PIX_W-1:0]   xCoord,
  input  logic [PIX_W-1:0]   yCoord,
  input  logic               target_hit,
  output logic [COORD_W-1:0] laser_xCoord,
  output logic [COORD_W-1:0] laser_yCoord,
  output logic               laser_active,
  output logic               hit_pulse,
  output logic               is_laser,
  output logic [RGB_W-1:0]   rgb
);

  laser_state_e     state_q, state_d;
  laser_pos_t       pos_q, pos_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit_d;
  logic             active_d;

  logic fire_s1, fire_s2, fire_s2_q;
  logic fire_edge;
  logic frame_tick;

  frame_tick_gen u_frame_tick (
    .clk        (clk),
    .rst        (rst),
    .xCoord     (xCoord),
    .yCoord     (yCoord),
    .frame_tick (frame_tick)
  );

  // Fire button synchroniser and press detector.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fire_s1   <= 1'b0;
      fire_s2   <= 1'b0;
      fire_s2_q <= 1'b0;
    end else begin
      fire_s1   <= fire;
      fire_s2   <= fire_s1;
      fire_s2_q <= fire_s2;
    end
  end

  assign fire_edge = fire_s2 && !fire_s2_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      pos_q        <= '{x: PARK_COORD, y: PARK_COORD};
      cnt_q        <= '0;
      hit_pulse    <= 1'b0;
      laser_active <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      cnt_q        <= cnt_d;
      hit_pulse    <= hit_d;
      laser_active <= active_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    hit_d   = 1'b0;

    if (restart || (mode != MODE_PLAY)) begin
      state_d = IDLE;
      pos_d   = '{x: PARK_COORD, y: PARK_COORD};
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fire_edge) begin
            state_d = FLYING;
            pos_d.x = spaceship_xCoord;
            pos_d.y = COORD_W'(SPACESHIP_Y - LASER_HEIGHT);
          end
        end
        // A hit outranks motion when both land in the same cycle.
        FLYING: begin
          if (target_hit) begin
            state_d = HIT_HOLD;
            hit_d   = 1'b1;
          end else if (frame_tick) begin
            if (pos_q.y < LASER_SPEED) begin
              state_d = COOLDOWN;
              pos_d   = '{x: PARK_COORD, y: PARK_COORD};
              cnt_d   = '0;
            end else begin
              pos_d.y = COORD_W'(pos_q.y - LASER_SPEED);
            end
          end
        end
        HIT_HOLD: begin
          if (frame_tick) begin
            state_d = COOLDOWN;
            pos_d   = '{x: PARK_COORD, y: PARK_COORD};
            cnt_d   = '0;
          end
        end
        COOLDOWN: begin
          if (frame_tick) begin
            if (CNT_W'(cnt_q + 4'd1) == COOLDOWN_FRAMES) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = CNT_W'(cnt_q + 4'd1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          pos_d   = '{x: PARK_COORD, y: PARK_COORD};
          cnt_d   = '0;
        end
      endcase
    end

    active_d = (state_d == FLYING) || (state_d == HIT_HOLD);
  end

  assign laser_xCoord = pos_q.x;
  assign laser_yCoord = pos_q.y;

  // Pixel coverage test against the live laser rectangle.
  logic [COORD_W-1:0] px, py, x_lo, x_hi, y_hi;

  assign px   = {1'b0, xCoord};
  assign py   = {1'b0, yCoord};
  assign x_lo = clamp_left(pos_q.x, LASER_HALF_W);
  assign x_hi = COORD_W'(pos_q.x + LASER_HALF_W);
  assign y_hi = COORD_W'(pos_q.y + LASER_HEIGHT - 11'd1);

  assign is_laser = laser_active && (px >= x_lo) && (px <= x_hi)
                    && (py >= pos_q.y) && (py <= y_hi);
  assign rgb      = is_laser ? COLOR_LASER : COLOR_BLACK;

endmodule

// File: tb/tb_spaceship_laser.sv
// Self-checking bench for spaceship_laser: directed scenarios plus randomized shots against a shot-level model.
module tb_spaceship_laser;

  logic        clk = 1'b0;
  logic        rst;
  logic        restart;
  logic [1:0]  mode;
  logic        fire;
  logic [10:0] spaceship_xCoord;
  logic [9:0]  xCoord;
  logic [9:0]  yCoord;
  logic        target_hit;
  logic [10:0] laser_xCoord;
  logic [10:0] laser_yCoord;
  logic        laser_active;
  logic        hit_pulse;
  logic        is_laser;
  logic [7:0]  rgb;

  int n_cmp  = 0;
  int n_fail = 0;

  // Shot-level model: phase 0 ready, 1 climbing, 2 hit shown, 3 recharging.
  int m_phase = 0;
  int m_x = 0;
  int m_y = 0;
  int m_wait = 0;
  int m_pulse = 0;

  always #5 clk = ~clk;

  spaceship_laser dut (
    .clk              (clk),
    .rst              (rst),
    .restart          (restart),
    .mode             (mode),
    .fire             (fire),
    .spaceship_xCoord (spaceship_xCoord),
    .xCoord           (xCoord),
    .yCoord           (yCoord),
    .target_hit       (target_hit),
    .laser_xCoord     (laser_xCoord),
    .laser_yCoord     (laser_yCoord),
    .laser_active     (laser_active),
    .hit_pulse        (hit_pulse),
    .is_laser         (is_laser),
    .rgb              (rgb)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    bit live;
    live = (m_phase == 1) || (m_phase == 2);
    check({tag, ".x"},      32'(laser_xCoord), live ? 32'(m_x) : 32'd2047);
    check({tag, ".y"},      32'(laser_yCoord), live ? 32'(m_y) : 32'd2047);
    check({tag, ".active"}, 32'(laser_active), 32'(live));
    check({tag, ".pulse"},  32'(hit_pulse),    32'(m_pulse));
  endtask

  task automatic model_park();
    m_phase = 0;
    m_wait  = 0;
    m_pulse = 0;
  endtask

  // One video frame: raster at origin for a cycle, then elsewhere.
  task automatic frame();
    xCoord = 10'd0;
    yCoord = 10'd0;
    step();
    xCoord = 10'd5;
    yCoord = 10'd5;
    step();
    m_pulse = 0;
    case (m_phase)
      1: begin
        if (m_y - 4 < 0) begin m_phase = 3; m_wait = 8; end
        else m_y = m_y - 4;
      end
      2: begin m_phase = 3; m_wait = 8; end
      3: begin
        m_wait--;
        if (m_wait == 0) m_phase = 0;
      end
      default: ;
    endcase
  endtask

  // Full press and release, long enough for the synchroniser to settle.
  task automatic press_fire(input logic [10:0] sx);
    spaceship_xCoord = sx;
    fire = 1'b1;
    repeat (3) step();
    if (m_phase == 0) begin
      m_phase = 1;
      m_x = int'(sx);
      m_y = 430;
    end
    check("launch", 32'(laser_active), 32'((m_phase == 1) || (m_phase == 2)));
    fire = 1'b0;
    repeat (3) step();
  endtask

  task automatic pulse_hit();
    target_hit = 1'b1;
    step();
    if (m_phase == 1) begin m_phase = 2; m_pulse = 1; end
    check_outputs("hit");
    target_hit = 1'b0;
    step();
    m_pulse = 0;
    check_outputs("hit_after");
  endtask

  task automatic check_pixel(input int px, input int py);
    bit on;
    int lo;
    lo = (m_x - 1 < 0) ? 0 : m_x - 1;
    on = ((m_phase == 1) || (m_phase == 2)) && px >= lo && px <= m_x + 1
         && py >= m_y && py <= m_y + 9;
    xCoord = 10'(px);
    yCoord = 10'(py);
    #1;
    check("is_laser", 32'(is_laser), 32'(on));
    check("rgb",      32'(rgb),      on ? 32'hFF : 32'h0);
    xCoord = 10'd5;
    yCoord = 10'd5;
    step();
  endtask

  initial begin
    rst = 1'b0; restart = 1'b0; mode = 2'd2; fire = 1'b0;
    spaceship_xCoord = 11'd320; xCoord = 10'd5; yCoord = 10'd5; target_hit = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    check_outputs("reset");

    // Full climb to the top edge.
    press_fire(11'd320);
    check_outputs("launch320");
    for (int k = 1; k <= 108; k++) begin
      frame();
      check_outputs("climb");
    end
    check("parked_y", 32'(laser_yCoord), 32'd2047);

    // Presses during recharge are dropped; first press after the 8th frame launches.
    for (int k = 0; k < 8; k++) begin
      press_fire(11'd100);
      check_outputs("cool_fire");
      frame();
    end
    press_fire(11'd100);
    check_outputs("after_cool");

    // Reset held mid-flight.
    repeat (5) frame();
    rst = 1'b0;
    repeat (3) step();
    model_park();
    check_outputs("reset_mid");
    rst = 1'b1;
    step();

    // Hit at row 86, hold through the next frame, second hit ignored.
    press_fire(11'd320);
    repeat (86) frame();
    check_outputs("pre_hit");
    pulse_hit();
    step();
    check_outputs("hold");
    pulse_hit();
    frame();
    check_outputs("hit_parked");
    pulse_hit();

    // Fire held throughout the recharge never launches.
    repeat (2) frame();
    fire = 1'b1;
    repeat (3) step();
    repeat (12) frame();
    check_outputs("held_fire");
    fire = 1'b0;
    repeat (3) step();
    check_outputs("held_release");

    // Mode change parks immediately; returning needs a new press.
    press_fire(11'd200);
    repeat (3) frame();
    mode = 2'd1;
    step();
    model_park();
    check_outputs("mode1");
    mode = 2'd2;
    repeat (4) step();
    check_outputs("mode2_back");
    press_fire(11'd200);
    restart = 1'b1;
    step();
    model_park();
    check_outputs("restart");
    restart = 1'b0;
    step();

    // Pixel coverage around (320,202).
    press_fire(11'd320);
    repeat (57) frame();
    check_outputs("pix_pos");
    for (int dx = -2; dx <= 2; dx++) begin
      check_pixel(320 + dx, 201);
      check_pixel(320 + dx, 202);
      check_pixel(320 + dx, 207);
      check_pixel(320 + dx, 211);
      check_pixel(320 + dx, 212);
    end
    restart = 1'b1; step(); model_park(); restart = 1'b0; step();

    // Left-edge clamp.
    press_fire(11'd0);
    check_pixel(0, 430);
    check_pixel(1, 430);
    check_pixel(2, 430);
    check_pixel(1023, 430);
    restart = 1'b1; step(); model_park(); restart = 1'b0; step();

    // Randomized shots.
    for (int s = 0; s < 8; s++) begin
      press_fire(11'($urandom_range(0, 639)));
      for (int f = 0; f < int'($urandom_range(0, 115)); f++) begin
        frame();
        check_outputs("rnd_climb");
        if ($urandom_range(0, 19) == 0) pulse_hit();
      end
      check_pixel(m_x + int'($urandom_range(0, 2)) - 1, m_y + int'($urandom_range(0, 11)));
      check_pixel(int'($urandom_range(0, 639)), int'($urandom_range(1, 479)));
      pulse_hit();
      for (int g = 0; g < 200 && m_phase != 0; g++) begin
        if ($urandom_range(0, 3) == 0) press_fire(11'($urandom_range(0, 639)));
        frame();
        check_outputs("rnd_drain");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
